// File: rtl/rst_seq_gen.sv
// rst_seq_gen - power-on / PLL-lock reset sequencer for the HDMI TX path.
//
// Waits for a synchronized PLL lock, holds off for HOLD_CYCLES qualified
// cycles, then releases NUM_STAGES active-low resets one at a time (bit 0
// first) with STAGE_GAP cycles between releases. Losing lock after the first
// release drops every output on the next edge and bumps a saturating
// lock-loss counter.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous reset, active-low
//   pll_locked     PLL lock flag (asynchronous, 2-flop synchronized here)
//   soft_rst       synchronous active-high restart (only with the macro below)
//   rst_n_out      staged resets, active-low, bit 0 released first
//   seq_done       high while every stage is released
//   lock_lost_cnt  saturating count of lock-loss events
//
// Build option: define RST_SEQ_SOFT_RST_EN to add the soft_rst input.

module rst_seq_gen #(
   parameter int HOLD_CYCLES = 1000,
   parameter int STAGE_GAP   = 16,
   parameter int NUM_STAGES  = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pll_locked,
`ifdef RST_SEQ_SOFT_RST_EN
   input  logic                  soft_rst,
`endif
   output logic [NUM_STAGES-1:0] rst_n_out,
   output logic                  seq_done,
   output logic [7:0]            lock_lost_cnt
);

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_HOLD      = 2'd1;
   localparam logic [1:0] ST_STAGE     = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;

   // Counters only need to reach their terminal value minus one.
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
   localparam logic [3:0]    LAST_IDX  = 4'(NUM_STAGES - 1);

   logic                  sync_meta_reg;
   logic                  lock_s_reg;
   logic [1:0]            state_reg, state_next;
   logic [HW-1:0]         hold_cnt_reg, hold_cnt_next;
   logic [GW-1:0]         gap_cnt_reg, gap_cnt_next;
   logic [3:0]            stage_idx_reg, stage_idx_next;
   logic [NUM_STAGES-1:0] rst_n_reg, rst_n_next;
   logic                  seq_done_reg, seq_done_next;
   logic [7:0]            lost_cnt_reg, lost_cnt_next;
   logic                  lock_loss;
   logic [NUM_STAGES-1:0] release_mask;

   // One-hot mask selecting the next stage to release.
   generate
      for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
         assign release_mask[gi] = ((stage_idx_reg + 4'd1) == 4'(gi));
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      hold_cnt_next  = hold_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      stage_idx_next = stage_idx_reg;
      rst_n_next     = rst_n_reg;
      seq_done_next  = seq_done_reg;
      lost_cnt_next  = lost_cnt_reg;
      lock_loss      = 1'b0;

      case (state_reg)
         ST_WAIT_LOCK: begin
            rst_n_next     = '0;
            seq_done_next  = 1'b0;
            hold_cnt_next  = '0;
            gap_cnt_next   = '0;
            stage_idx_next = '0;
            if (lock_s_reg) begin
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!lock_s_reg) begin
               // Lock dropped before any release: restart silently.
               state_next    = ST_WAIT_LOCK;
               hold_cnt_next = '0;
            end else if (hold_cnt_reg == HOLD_LAST) begin
               hold_cnt_next  = '0;
               gap_cnt_next   = '0;
               stage_idx_next = '0;
               rst_n_next     = NUM_STAGES'(1);
               if (NUM_STAGES == 1) begin
                  seq_done_next = 1'b1;
                  state_next    = ST_RUN;
               end else begin
                  state_next = ST_STAGE;
               end
            end else begin
               hold_cnt_next = hold_cnt_reg + 1'b1;
            end
         end
         ST_STAGE: begin
            if (!lock_s_reg) begin
               lock_loss = 1'b1;
            end else if (gap_cnt_reg == GAP_LAST) begin
               gap_cnt_next   = '0;
               rst_n_next     = rst_n_reg | release_mask;
               stage_idx_next = stage_idx_reg + 4'd1;
               if ((stage_idx_reg + 4'd1) == LAST_IDX) begin
                  seq_done_next = 1'b1;
                  state_next    = ST_RUN;
               end
            end else begin
               gap_cnt_next = gap_cnt_reg + 1'b1;
            end
         end
         ST_RUN: begin
            if (!lock_s_reg) begin
               lock_loss = 1'b1;
            end
         end
         default: state_next = ST_WAIT_LOCK;
      endcase

      // Lock lost after at least one stage was released.
      if (lock_loss) begin
         state_next     = ST_WAIT_LOCK;
         hold_cnt_next  = '0;
         gap_cnt_next   = '0;
         stage_idx_next = '0;
         rst_n_next     = '0;
         seq_done_next  = 1'b0;
         if (lost_cnt_reg != 8'hFF) begin
            lost_cnt_next = lost_cnt_reg + 8'd1;
         end
      end

`ifdef RST_SEQ_SOFT_RST_EN
      // Soft restart overrides everything except the loss counter, which
      // still records a coincident loss from STAGE/RUN above.
      if (soft_rst) begin
         state_next     = ST_WAIT_LOCK;
         hold_cnt_next  = '0;
         gap_cnt_next   = '0;
         stage_idx_next = '0;
         rst_n_next     = '0;
         seq_done_next  = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta_reg <= 1'b0;
         lock_s_reg    <= 1'b0;
         state_reg     <= ST_WAIT_LOCK;
         hold_cnt_reg  <= '0;
         gap_cnt_reg   <= '0;
         stage_idx_reg <= '0;
         rst_n_reg     <= '0;
         seq_done_reg  <= 1'b0;
         lost_cnt_reg  <= 8'd0;
      end else begin
         sync_meta_reg <= pll_locked;
         lock_s_reg    <= sync_meta_reg;
         state_reg     <= state_next;
         hold_cnt_reg  <= hold_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         stage_idx_reg <= stage_idx_next;
         rst_n_reg     <= rst_n_next;
         seq_done_reg  <= seq_done_next;
         lost_cnt_reg  <= lost_cnt_next;
      end
   end

   assign rst_n_out     = rst_n_reg;
   assign seq_done      = seq_done_reg;
   assign lock_lost_cnt = lost_cnt_reg;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Testbench for rst_seq_gen with HOLD_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3.
// Reference model: lock_s is pll_locked delayed two edges; the outputs are a
// pure function of how many consecutive edges lock_s has been high.
module tb_rst_seq_gen;
   localparam int HOLD = 8;
   localparam int GAP  = 4;
   localparam int NS   = 3;
   localparam int THR  = 1 + HOLD;   // run length at which bit 0 releases

   logic          clk = 1'b0;
   logic          reset_n;
   logic          pll_locked;
   logic          soft_rst;
   logic [NS-1:0] rst_n_out;
   logic          seq_done;
   logic [7:0]    lock_lost_cnt;

   int checks = 0;
   int errors = 0;

   // model state
   bit m_s1, m_s2;
   int m_len;
   int m_cnt;

   typedef struct {
      int         pat;
      int         edge_n;
      logic [2:0] rst;
      logic       done;
      logic [7:0] cnt;
   } vec_t;
   vec_t vt[18];

   rst_seq_gen #(
      .HOLD_CYCLES(HOLD),
      .STAGE_GAP  (GAP),
      .NUM_STAGES (NS)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
`ifdef RST_SEQ_SOFT_RST_EN
      .soft_rst     (soft_rst),
`endif
      .rst_n_out    (rst_n_out),
      .seq_done     (seq_done),
      .lock_lost_cnt(lock_lost_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NS-1:0] exp_rst(input int len);
      logic [NS-1:0] r;
      for (int k = 0; k < NS; k++) r[k] = (len >= THR + k * GAP);
      return r;
   endfunction

   function automatic bit pat_lock(input int pat, input int e);
      if (e < 0) return 1'b0;
      if (pat == 0) return (e < 30 || e >= 40);
      return (e != 5);
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_len = 0; m_cnt = 0;
   endtask

   // One clock: drive inputs, advance the model at the edge, compare at negedge.
   task automatic step(input bit lk, input bit sr);
      bit ls;
      pll_locked = lk;
      soft_rst   = sr;
      @(posedge clk);
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      if (!ls) begin
         if (m_len >= THR && m_cnt < 255) m_cnt++;
         m_len = 0;
      end else begin
         m_len++;
      end
      if (sr) m_len = 0;
      @(negedge clk);
      chk("model_rst_n_out", rst_n_out, exp_rst(m_len));
      chk("model_seq_done", seq_done, (m_len >= THR + (NS - 1) * GAP) ? 1 : 0);
      chk("model_lock_lost_cnt", lock_lost_cnt, m_cnt);
      $display("step lk=%0b sr=%0b rst_n_out=%b seq_done=%0b cnt=%0d", lk, sr,
               rst_n_out, seq_done, lock_lost_cnt);
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      soft_rst   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_rst_n_out", rst_n_out, 0);
      chk("reset_seq_done", seq_done, 0);
      chk("reset_cnt", lock_lost_cnt, 0);
      reset_n = 1'b1;
   endtask

   task automatic run_pat(input int pat, input int last);
      for (int e = -2; e <= last; e++) begin
         step(pat_lock(pat, e), 1'b0);
         for (int i = 0; i < 18; i++) begin
            if (vt[i].pat == pat && vt[i].edge_n == e) begin
               chk($sformatf("p%0d_e%0d_rst", pat, e), rst_n_out, vt[i].rst);
               chk($sformatf("p%0d_e%0d_done", pat, e), seq_done, vt[i].done);
               chk($sformatf("p%0d_e%0d_cnt", pat, e), lock_lost_cnt, vt[i].cnt);
            end
         end
      end
   endtask

   initial begin
      int n;
      // pattern 0: basic sequence, loss in RUN at edge 30, relock at edge 40
      vt[0]  = '{0,  9, 3'b000, 1'b0, 8'd0};
      vt[1]  = '{0, 10, 3'b001, 1'b0, 8'd0};
      vt[2]  = '{0, 13, 3'b001, 1'b0, 8'd0};
      vt[3]  = '{0, 14, 3'b011, 1'b0, 8'd0};
      vt[4]  = '{0, 17, 3'b011, 1'b0, 8'd0};
      vt[5]  = '{0, 18, 3'b111, 1'b1, 8'd0};
      vt[6]  = '{0, 31, 3'b111, 1'b1, 8'd0};
      vt[7]  = '{0, 32, 3'b000, 1'b0, 8'd1};
      vt[8]  = '{0, 49, 3'b000, 1'b0, 8'd1};
      vt[9]  = '{0, 50, 3'b001, 1'b0, 8'd1};
      vt[10] = '{0, 54, 3'b011, 1'b0, 8'd1};
      vt[11] = '{0, 58, 3'b111, 1'b1, 8'd1};
      // pattern 1: one-cycle glitch at edge 5 during HOLD
      vt[12] = '{1, 10, 3'b000, 1'b0, 8'd0};
      vt[13] = '{1, 15, 3'b000, 1'b0, 8'd0};
      vt[14] = '{1, 16, 3'b001, 1'b0, 8'd0};
      vt[15] = '{1, 20, 3'b011, 1'b0, 8'd0};
      vt[16] = '{1, 24, 3'b111, 1'b1, 8'd0};
      vt[17] = '{1, 30, 3'b111, 1'b1, 8'd0};

      do_reset();
      run_pat(0, 60);

      // reset asserted mid-STAGE: outputs must clear without a clock edge
      repeat (3) step(1'b0, 1'b0);
      n = 0;
      while (rst_n_out != 3'b001 && n < 40) begin
         step(1'b1, 1'b0);
         n++;
      end
      chk("midstage_reached_001", rst_n_out, 3'b001);
      chk("midstage_cnt_before", lock_lost_cnt, 2);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_rst_n_out", rst_n_out, 0);
      chk("async_reset_seq_done", seq_done, 0);
      chk("async_reset_cnt", lock_lost_cnt, 0);
      model_reset();
      pll_locked = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      run_pat(1, 30);

      // randomized lock waveform against the model
      for (int s = 0; s < 40; s++) begin
         int hi, lo;
         hi = $urandom_range(1, 30);
         lo = $urandom_range(1, 4);
         repeat (hi) step(1'b1, 1'b0);
         repeat (lo) step(1'b0, 1'b0);
      end

`ifdef RST_SEQ_SOFT_RST_EN
      repeat (25) step(1'b1, 1'b0);
      chk("soft_pre_run", rst_n_out, 3'b111);
      step(1'b1, 1'b1);
      chk("soft_edge_rst", rst_n_out, 0);
      repeat (8) step(1'b1, 1'b0);
      chk("soft_hold_rst", rst_n_out, 0);
      step(1'b1, 1'b0);
      chk("soft_release_rst", rst_n_out, 3'b001);
`endif

      // saturation: 300 losses, each after full release
      for (int i = 0; i < 300; i++) begin
         repeat (22) step(1'b1, 1'b0);
         repeat (3) step(1'b0, 1'b0);
      end
      chk("sat_cnt", lock_lost_cnt, 255);
      repeat (22) step(1'b1, 1'b0);
      chk("sat_full_release", rst_n_out, 3'b111);
      repeat (3) step(1'b0, 1'b0);
      chk("sat_cnt_holds", lock_lost_cnt, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Power-on / PLL-lock reset sequencer that produces the active-low resets consumed by the per-domain reset synchronizers in the HDMI TX path.
- Qualifies the PLL lock flag with a hold-off period.
- Releases NUM_STAGES reset outputs one at a time, in order, with a fixed gap between releases.
- Re-asserts all outputs together on lock loss, and counts lock-loss events for debug.

Parameters:
- HOLD_CYCLES, 1000: cycles the synchronized lock must stay high before stage 0 is released; legal range >= 1.
- STAGE_GAP, 16: cycles between consecutive stage releases; legal range >= 1.
- NUM_STAGES, 3: number of staged reset outputs; legal range 1..8.

Ports:
- clk  input  1: system clock.
- reset_n  input  1: asynchronous reset, active-low.
- pll_locked  input  1: PLL lock flag, asynchronous to clk; synchronized internally with 2 flops.
- rst_n_out  output  NUM_STAGES: staged resets, active-low; bit 0 is released first.
- seq_done  output  1: high while every stage is released.
- lock_lost_cnt  output  8: saturating count of lock-loss events.

Behaviour:
- Reset. While reset_n is low, asynchronously:
  - synchronizer flops = 0, state = WAIT_LOCK, counters = 0;
  - rst_n_out = all 0, seq_done = 0, lock_lost_cnt = 0.
- All outputs are registered.
- Let lock_s be the output of the 2-flop synchronizer. If edge E is the first edge that samples a new pll_locked value, lock_s shows that value after edge E+1.
- WAIT_LOCK:
  - rst_n_out = 0, seq_done = 0, hold counter cleared.
  - lock_s == 1 -> HOLD.
- HOLD:
  - Hold counter increments each cycle while lock_s == 1.
  - lock_s == 0 -> WAIT_LOCK, counter cleared, lock_lost_cnt unchanged.
  - HOLD_CYCLES qualified cycles complete -> rst_n_out[0] = 1 on that edge, stage index = 0, go to STAGE.
  - Required timing: rst_n_out[0] rises at edge E+2+HOLD_CYCLES.
- STAGE:
  - Gap counter runs; every STAGE_GAP cycles the next bit of rst_n_out is set.
  - rst_n_out[k] rises exactly k*STAGE_GAP edges after rst_n_out[0].
  - Released bits never re-assert individually. Release is monotonic, low index to high.
  - On the edge that sets bit NUM_STAGES-1: seq_done = 1, go to RUN.
  - NUM_STAGES == 1: seq_done rises on the same edge as rst_n_out[0], and the state goes directly to RUN.
- RUN: outputs hold; seq_done = 1.
- Lock loss in STAGE or RUN (lock_s == 0):
  - On the next edge: rst_n_out = all 0, seq_done = 0, state = WAIT_LOCK, counters cleared.
  - lock_lost_cnt increments by 1, saturating at 255.
  - Net effect: outputs go low at edge E+2, where E is the first edge sampling pll_locked = 0.
- Lock re-acquired: the full sequence restarts with a complete HOLD_CYCLES hold-off.
- Any pll_locked glitch shorter than 1 cycle that is captured by the synchronizer counts as a loss.
- Illegal parameter values are out of scope. Behaviour is undefined; no runtime check is required.

Optional Feature:
- Macro RST_SEQ_SOFT_RST_EN.
- When defined, adds port: soft_rst  input  1, synchronous to clk, active-high.
  - soft_rst == 1 in any state -> on the next edge: rst_n_out = 0, seq_done = 0, state = WAIT_LOCK, counters cleared.
  - lock_lost_cnt is not incremented by soft_rst.
  - While soft_rst stays high, the block remains in WAIT_LOCK.
  - When soft_rst and lock loss occur on the same cycle, lock_lost_cnt increments only if the state was STAGE or RUN.
- When not defined: the port is absent and the block behaves exactly as specified above.

Test Plan:
All tests use HOLD_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3.
1. Basic sequence:
   - Stimulus: release reset_n; pll_locked = 1 first sampled at edge 0.
   - Required: rst_n_out = 001 at edge 10, 011 at edge 14, 111 and seq_done = 1 at edge 18; lock_lost_cnt = 0.
2. Glitch during HOLD:
   - Stimulus: pll_locked low for 1 cycle at edge 5, high again at edge 6.
   - Required: no release before edge 16; rst_n_out[0] rises at edge 16; lock_lost_cnt = 0.
3. Lock loss in RUN:
   - Stimulus: pll_locked = 0 first sampled at edge 30.
   - Required: rst_n_out = 000 and seq_done = 0 at edge 32; lock_lost_cnt = 1.
   - Relock sampled at edge 40 -> rst_n_out = 001 at edge 50.
4. Counter saturation:
   - Stimulus: 300 loss events, each occurring after full release.
   - Required: lock_lost_cnt = 255 and holds at 255.
5. Reset mid-STAGE:
   - Stimulus: reset_n pulled low between edges 12 and 13, with rst_n_out = 001.
   - Required: rst_n_out = 000, seq_done = 0 and lock_lost_cnt = 0 immediately, without waiting for a clock edge; after release of reset_n, a full resequence.
6. Soft reset (RST_SEQ_SOFT_RST_EN defined):
   - Stimulus: soft_rst pulsed for 1 cycle in RUN at edge 40.
   - Required: rst_n_out = 000 at edge 41; lock_lost_cnt unchanged; with pll_locked still high, rst_n_out = 001 at edge 41+1+8 = 50.
